led_ctrl_top: RTL and testbench

LED_CTRL_TOP -- requirements
Module: led_ctrl_top

---
 rtl/led_ctrl_top.sv | 196 +++++++++++++++++++
 tb/tb_led_ctrl_top.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_ctrl_top.sv
// led_ctrl_top
//   Captures a frame of per-LED colour levels into a small FIFO and plays frames
//   back as NUM_LED parallel serial lanes with a shared serial clock.
//
//   Writer : a start pulse snapshots MeanR/MeanG/MeanB. The frame is then written
//            as NUM_LED words over the next NUM_LED cycles. The whole frame is dropped
//            when the FIFO cannot hold it.
//   FIFO   : FIFO_DEPTH x 12 words, with write and read allowed in the same cycle.
//   Sender : an en pulse in IDLE with at least one frame available starts a
//            transmission. It runs IDLE -> LOAD (NUM_LED reads) -> SHIFT (12 bits
//            MSB-first, two cycles per bit) and then returns to IDLE.
//
// Ports
//   clk_fast            sole clock, rising edge
//   rstn                asynchronous active-low reset
//   start, en           single-cycle request pulses (capture frame / send frame)
//   MeanR/MeanG/MeanB   per-LED 4-bit colour levels
//   we, fifo_data_in    FIFO write strobe and word {R,G,B}
//   rd, fifo_data_out   FIFO read strobe and registered read word
//   send_start          one-cycle pulse at the start of a transmission
//   empty_flag          FIFO holds no words
//   cko_o, sdo          serial clock and one data bit per LED lane
module led_ctrl_top #(
    parameter int NUM_LED    = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               clk_fast,
    input  logic               rstn,
    input  logic               start,
    input  logic               en,
    input  logic [3:0]         MeanR [NUM_LED-1:0],
    input  logic [3:0]         MeanG [NUM_LED-1:0],
    input  logic [3:0]         MeanB [NUM_LED-1:0],
    output logic               we,
    output logic [11:0]        fifo_data_in,
    output logic               rd,
    output logic [11:0]        fifo_data_out,
    output logic               send_start,
    output logic               empty_flag,
    output logic               cko_o,
    output logic [NUM_LED-1:0] sdo
);

    localparam int WORD_W       = 12;
    localparam int IDX_W        = (NUM_LED > 1) ? $clog2(NUM_LED) : 1;
    localparam int LIDX_W       = IDX_W + 1;
    localparam int PTR_W        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W        = $clog2(FIFO_DEPTH + 1);
    localparam int SHIFT_CYCLES = 2 * WORD_W;
    localparam int BIT_CNT_W    = $clog2(SHIFT_CYCLES);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t                state;
    logic [WORD_W-1:0]     snap [NUM_LED];
    logic [WORD_W-1:0]     mem  [FIFO_DEPTH];
    logic [WORD_W-1:0]     sh   [NUM_LED];
    logic [LIDX_W-1:0]     wr_idx;
    logic [IDX_W-1:0]      ld_idx;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [PTR_W-1:0]      wptr;
    logic [PTR_W-1:0]      rptr;
    logic [CNT_W-1:0]      count;
    logic [WORD_W-1:0]     rd_word;
    logic                  wr_accept;
    logic                  send_accept;

    assign rd_word    = mem[rptr];
    assign empty_flag = (count == '0);

    // The writer is busy exactly while its burst is on we. Free space is checked
    // once, at acceptance. Reads can only grow free space after that point.
    assign wr_accept   = start && !we && ((FIFO_DEPTH - int'(count)) >= NUM_LED);
    // A word being written in this same cycle already counts toward a full frame.
    assign send_accept = en && (state == IDLE) && ((int'(count) + int'(we)) >= NUM_LED);

    // Writer: word 0 goes out straight from the inputs. Words 1..N-1 come from the snapshot.
    always_ff @(posedge clk_fast or negedge rstn) begin
        if (!rstn) begin
            we           <= 1'b0;
            fifo_data_in <= '0;
            wr_idx       <= '0;
        end else if (we) begin
            if (wr_idx == LIDX_W'(NUM_LED)) begin
                we <= 1'b0;
            end else begin
                fifo_data_in <= snap[wr_idx[IDX_W-1:0]];
                wr_idx       <= wr_idx + 1'b1;
            end
        end else if (wr_accept) begin
            we           <= 1'b1;
            fifo_data_in <= {MeanR[0], MeanG[0], MeanB[0]};
            wr_idx       <= LIDX_W'(1);
        end
    end

    always_ff @(posedge clk_fast) begin
        if (wr_accept) begin
            for (int i = 0; i < NUM_LED; i++) begin
                snap[i] <= {MeanR[i], MeanG[i], MeanB[i]};
            end
        end
        if (we) begin
            mem[wptr] <= fifo_data_in;
        end
    end

    // FIFO pointers, occupancy and registered read port
    always_ff @(posedge clk_fast or negedge rstn) begin
        if (!rstn) begin
            wptr          <= '0;
            rptr          <= '0;
            count         <= '0;
            fifo_data_out <= '0;
        end else begin
            if (we) begin
                wptr <= (wptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wptr + 1'b1;
            end
            if (rd) begin
                rptr          <= (rptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rptr + 1'b1;
                fifo_data_out <= rd_word;
            end
            case ({we, rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Lane shift registers: loaded in read order, then shifted at the end of each bit
    always_ff @(posedge clk_fast) begin
        if (rd) begin
            sh[ld_idx] <= rd_word;
        end else if ((state == SHIFT) && cko_o) begin
            for (int k = 0; k < NUM_LED; k++) begin
                sh[k] <= {sh[k][WORD_W-2:0], 1'b0};
            end
        end
    end

    // Sender FSM. rd is high for every LOAD cycle. The last lane is loaded on the
    // same edge that enters SHIFT, so its first bit is taken from the read word.
    always_ff @(posedge clk_fast or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            send_start <= 1'b0;
            rd         <= 1'b0;
            cko_o      <= 1'b0;
            sdo        <= '0;
            ld_idx     <= '0;
            bit_cnt    <= '0;
        end else begin
            send_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (send_accept) begin
                        state      <= LOAD;
                        send_start <= 1'b1;
                        rd         <= 1'b1;
                        ld_idx     <= '0;
                    end
                end
                LOAD: begin
                    ld_idx <= ld_idx + 1'b1;
                    if (ld_idx == IDX_W'(NUM_LED - 1)) begin
                        rd      <= 1'b0;
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        cko_o   <= 1'b0;
                        for (int k = 0; k < NUM_LED; k++) begin
                            sdo[k] <= (k == NUM_LED - 1) ? rd_word[WORD_W-1] : sh[k][WORD_W-1];
                        end
                    end
                end
                SHIFT: begin
                    bit_cnt <= bit_cnt + 1'b1;
                    cko_o   <= ~cko_o;
                    // Data advances only while cko_o is about to fall.
                    if (cko_o) begin
                        for (int k = 0; k < NUM_LED; k++) begin
                            sdo[k] <= sh[k][WORD_W-2];
                        end
                    end
                    if (bit_cnt == BIT_CNT_W'(SHIFT_CYCLES - 1)) begin
                        state <= IDLE;
                        cko_o <= 1'b0;
                        sdo   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_ctrl_top.sv
// Testbench for led_ctrl_top: a transaction-level model (word queue plus
// per-cycle expectation tables) is checked every cycle, and directed scenarios
// pin the model with literal values.
module tb_led_ctrl_top;

    localparam int NUM_LED    = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int W          = 12;

    logic               clk_fast = 1'b0;
    logic               rstn     = 1'b1;
    logic               start    = 1'b0;
    logic               en       = 1'b0;
    logic [3:0]         MeanR [NUM_LED-1:0];
    logic [3:0]         MeanG [NUM_LED-1:0];
    logic [3:0]         MeanB [NUM_LED-1:0];
    logic               we;
    logic [11:0]        fifo_data_in;
    logic               rd;
    logic [11:0]        fifo_data_out;
    logic               send_start;
    logic               empty_flag;
    logic               cko_o;
    logic [NUM_LED-1:0] sdo;

    led_ctrl_top #(.NUM_LED(NUM_LED), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk_fast(clk_fast), .rstn(rstn), .start(start), .en(en),
        .MeanR(MeanR), .MeanG(MeanG), .MeanB(MeanB),
        .we(we), .fifo_data_in(fifo_data_in), .rd(rd), .fifo_data_out(fifo_data_out),
        .send_start(send_start), .empty_flag(empty_flag), .cko_o(cko_o), .sdo(sdo)
    );

    always #5 clk_fast = ~clk_fast;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk_fast) cyc = cyc + 1;

    // Reference model: FIFO contents and expected outputs indexed by cycle number
    logic [11:0] q [$];
    bit          exp_we  [int];
    logic [11:0] exp_din [int];
    bit          exp_rd  [int];
    bit          exp_ss  [int];
    logic [11:0] fdo_sched [int];
    bit          exp_cko [int];
    logic [7:0]  exp_sdo [int];
    logic [11:0] cur_fdo;
    logic [11:0] lanes [NUM_LED];
    int          wr_end, snd_end, ld_k;

    // Traces of DUT behaviour used by the directed checks
    int          tr_we, tr_rd, tr_ss, tr_cko;
    logic [11:0] din_log [$];
    logic [11:0] fdo_log [$];
    logic [11:0] lane0, lane7;
    bit          prev_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_we.delete(); exp_din.delete(); exp_rd.delete(); exp_ss.delete();
        fdo_sched.delete(); exp_cko.delete(); exp_sdo.delete();
        cur_fdo = '0;
        wr_end  = -1;
        snd_end = -1;
        ld_k    = 0;
    endtask

    task automatic model_step(input int c);
        int cnt = q.size();
        bit push = exp_we.exists(c);
        bit pop  = exp_rd.exists(c);
        logic [11:0] w;
        logic [7:0]  v;
        if (start && c > wr_end && (FIFO_DEPTH - cnt) >= NUM_LED) begin
            for (int i = 0; i < NUM_LED; i++) begin
                exp_we[c+1+i]  = 1'b1;
                exp_din[c+1+i] = {MeanR[i], MeanG[i], MeanB[i]};
            end
            wr_end = c + NUM_LED;
        end
        if (en && c > snd_end && (cnt + int'(push)) >= NUM_LED) begin
            exp_ss[c+1] = 1'b1;
            for (int k = 0; k < NUM_LED; k++) exp_rd[c+1+k] = 1'b1;
            snd_end = c + NUM_LED + 2 * W;
            ld_k    = 0;
        end
        if (pop && q.size() > 0) begin
            w = q.pop_front();
            fdo_sched[c+1] = w;
            lanes[ld_k]    = w;
            ld_k++;
            if (ld_k == NUM_LED) begin
                for (int b = 0; b < W; b++) begin
                    for (int k = 0; k < NUM_LED; k++) v[k] = lanes[k][W-1-b];
                    for (int p = 0; p < 2; p++) begin
                        exp_cko[c+1+2*b+p] = (p == 1);
                        exp_sdo[c+1+2*b+p] = v;
                    end
                end
            end
        end
        if (push) q.push_back(exp_din[c]);
    endtask

    // Compare process: mid-cycle, against the model's expectation for this cycle
    always @(negedge clk_fast) begin
        if (!rstn) begin
            chk("rst_we", we, 0);
            chk("rst_rd", rd, 0);
            chk("rst_send_start", send_start, 0);
            chk("rst_cko_o", cko_o, 0);
            chk("rst_sdo", sdo, 0);
            chk("rst_fifo_data_in", fifo_data_in, 0);
            chk("rst_fifo_data_out", fifo_data_out, 0);
            chk("rst_empty_flag", empty_flag, 1);
            model_reset();
            prev_rd = 1'b0;
        end else begin
            if (fdo_sched.exists(cyc)) cur_fdo = fdo_sched[cyc];
            chk("we", we, exp_we.exists(cyc));
            if (exp_we.exists(cyc)) chk("fifo_data_in", fifo_data_in, exp_din[cyc]);
            chk("rd", rd, exp_rd.exists(cyc));
            chk("send_start", send_start, exp_ss.exists(cyc));
            chk("fifo_data_out", fifo_data_out, cur_fdo);
            chk("empty_flag", empty_flag, q.size() == 0);
            chk("cko_o", cko_o, exp_cko.exists(cyc) ? exp_cko[cyc] : 1'b0);
            chk("sdo", sdo, exp_sdo.exists(cyc) ? exp_sdo[cyc] : 8'h00);
            if (we === 1'b1) begin tr_we++; din_log.push_back(fifo_data_in); end
            if (rd === 1'b1) tr_rd++;
            if (send_start === 1'b1) tr_ss++;
            if (prev_rd) fdo_log.push_back(fifo_data_out);
            if (cko_o === 1'b1) begin
                tr_cko++;
                lane0 = {lane0[10:0], sdo[0]};
                lane7 = {lane7[10:0], sdo[7]};
            end
            prev_rd = (rd === 1'b1);
            model_step(cyc);
        end
    end

    task automatic clear_trace();
        tr_we = 0; tr_rd = 0; tr_ss = 0; tr_cko = 0;
        din_log.delete(); fdo_log.delete();
        lane0 = '0; lane7 = '0;
    endtask

    task automatic pulse_start();
        @(posedge clk_fast); #1 start = 1'b1;
        @(posedge clk_fast); #1 start = 1'b0;
    endtask

    task automatic pulse_en();
        @(posedge clk_fast); #1 en = 1'b1;
        @(posedge clk_fast); #1 en = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_fast);
        #1;
    endtask

    initial begin
        for (int i = 0; i < NUM_LED; i++) begin
            MeanR[i] = '0; MeanG[i] = '0; MeanB[i] = '0;
        end
        clear_trace();
        #1 rstn = 1'b0;
        wait_cycles(3);
        rstn = 1'b1;
        chk("empty_after_reset", empty_flag, 1);

        // One frame with levels i+1 on every colour
        for (int i = 0; i < NUM_LED; i++) begin
            MeanR[i] = 4'(i + 1); MeanG[i] = 4'(i + 1); MeanB[i] = 4'(i + 1);
        end
        clear_trace();
        pulse_start();
        wait_cycles(10);
        chk("frame_we_cycles", tr_we, 8);
        for (int i = 0; i < NUM_LED; i++)
            chk("frame_word", (din_log.size() > i) ? 32'(din_log[i]) : 32'hFFFF_FFFF, 32'h111 * (i + 1));
        chk("empty_after_write", empty_flag, 0);

        // Transmit it
        clear_trace();
        pulse_en();
        wait_cycles(40);
        chk("tx_send_start_count", tr_ss, 1);
        chk("tx_rd_cycles", tr_rd, 8);
        for (int i = 0; i < NUM_LED; i++)
            chk("tx_read_word", (fdo_log.size() > i) ? 32'(fdo_log[i]) : 32'hFFFF_FFFF, 32'h111 * (i + 1));
        chk("tx_lane0_bits", lane0, 12'b0001_0001_0001);
        chk("tx_lane7_bits", lane7, 12'b1000_1000_1000);
        chk("tx_cko_pulses", tr_cko, 12);
        chk("empty_after_tx", empty_flag, 1);

        // en with an empty FIFO does nothing
        clear_trace();
        pulse_en();
        wait_cycles(40);
        chk("empty_en_send_start", tr_ss, 0);
        chk("empty_en_rd", tr_rd, 0);
        chk("empty_en_cko", tr_cko, 0);

        // Three frames with no en: the third one does not fit
        clear_trace();
        pulse_start(); wait_cycles(10);
        pulse_start(); wait_cycles(10);
        pulse_start(); wait_cycles(10);
        chk("three_starts_we_cycles", tr_we, 16);
        chk("three_starts_empty", empty_flag, 0);

        // Reset in the middle of SHIFT
        clear_trace();
        pulse_en();
        repeat (20) @(posedge clk_fast);
        #3 rstn = 1'b0;
        @(negedge clk_fast);
        chk("midshift_rst_sdo", sdo, 0);
        chk("midshift_rst_cko", cko_o, 0);
        chk("midshift_rst_empty", empty_flag, 1);
        chk("midshift_had_started", tr_ss, 1);
        @(posedge clk_fast); #1 rstn = 1'b1;
        clear_trace();
        pulse_en();
        wait_cycles(40);
        chk("post_rst_en_ignored", tr_ss, 0);
        chk("post_rst_en_no_rd", tr_rd, 0);
        pulse_start();
        wait_cycles(10);
        pulse_en();
        wait_cycles(40);
        chk("post_rst_new_frame_sent", tr_ss, 1);

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk_fast); #1;
            start = ($urandom_range(0, 5) == 0);
            en    = ($urandom_range(0, 5) == 0);
            for (int k = 0; k < NUM_LED; k++) begin
                MeanR[k] = 4'($urandom); MeanG[k] = 4'($urandom); MeanB[k] = 4'($urandom);
            end
            if (!rstn) rstn = 1'b1;
            else if ($urandom_range(0, 599) == 0) begin
                #2 rstn = 1'b0;
            end
        end
        @(posedge clk_fast); #1;
        start = 1'b0; en = 1'b0; rstn = 1'b1;
        wait_cycles(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
